// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encodings, bus mode and default word width.
// Used by spi_slave and spi_master so both ends of the bus agree on framing.
package spi_pkg;

   localparam int   SPI_WIDTH = 8;
   localparam logic SPI_CPOL  = 1'b0;
   localparam logic SPI_CPHA  = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_DONE,
      ST_WAIT_FALL
   } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI input with edge detect.
// Ports: clk_i, reset_n_i (sync, active low), d_i in; level_o, rise_o, fall_o out.
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic IDLE_VAL    = 1'b0
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_hist;

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         r_sync <= {SYNC_STAGES{IDLE_VAL}};
         r_hist <= IDLE_VAL;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], d_i};
         r_hist <= r_sync[SYNC_STAGES-1];
      end
   end

   assign level_o = r_sync[SYNC_STAGES-1];
   assign rise_o  = level_o & ~r_hist;
   assign fall_o  = ~level_o & r_hist;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversampled sclk/ss_n/mosi, rx deserialiser, staged tx word.
// Ports: SPI pins (sclk_i, ss_n_i, mosi_i, miso_o), core tx/rx handshakes, status pulses.
module spi_slave
   import spi_pkg::*;
#(
   parameter int WIDTH       = SPI_WIDTH,
   parameter int CT          = $clog2(WIDTH),
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             sclk_i,
   input  logic             ss_n_i,
   input  logic             mosi_i,
   output logic             miso_o,
   output logic             slave_ready_o,
   input  logic             enable_i,
   input  logic [WIDTH-1:0] tx_data_i,
   input  logic             tx_valid_i,
   output logic             tx_ready_o,
   output logic [WIDTH-1:0] rx_data_o,
   output logic             rx_valid_o,
   output logic             tx_underrun_o,
   output logic             frame_abort_o
);

   logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
   logic w_ss_lvl, w_ss_fall, w_unused_ss_rise;
   logic w_mosi, w_unused_mosi_rise, w_unused_mosi_fall;
   logic w_sample, w_drive;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(SPI_CPOL)) u_sclk (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .d_i       (sclk_i),
      .level_o   (w_sclk_lvl),
      .rise_o    (w_sclk_rise),
      .fall_o    (w_sclk_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_ss (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .d_i       (ss_n_i),
      .level_o   (w_ss_lvl),
      .rise_o    (w_unused_ss_rise),
      .fall_o    (w_ss_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_mosi (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .d_i       (mosi_i),
      .level_o   (w_mosi),
      .rise_o    (w_unused_mosi_rise),
      .fall_o    (w_unused_mosi_fall)
   );

   // Leading edge samples, trailing edge drives (mode 0: rise/fall).
   assign w_sample = (SPI_CPOL ^ SPI_CPHA) ? w_sclk_fall : w_sclk_rise;
   assign w_drive  = (SPI_CPOL ^ SPI_CPHA) ? w_sclk_rise : w_sclk_fall;

   spi_state_e       r_state, w_state_n;
   logic [WIDTH-1:0] r_tx_shift, w_tx_shift_n;
   logic [WIDTH-1:0] r_rx_shift, w_rx_shift_n;
   logic [WIDTH-1:0] r_hold, w_hold_n;
   logic [WIDTH-1:0] r_rx_data, w_rx_data_n;
   logic [CT-1:0]    r_count, w_count_n;
   logic             r_full, w_full_n;
   logic             r_miso, w_miso_n;
   logic             r_rx_valid, w_rx_valid_n;
   logic             r_under, w_under_n;
   logic             r_abort, w_abort_n;
   logic             r_sready;

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         r_state    <= ST_IDLE;
         r_tx_shift <= '0;
         r_rx_shift <= '0;
         r_hold     <= '0;
         r_rx_data  <= '0;
         r_count    <= '0;
         r_full     <= 1'b0;
         r_miso     <= 1'b0;
         r_rx_valid <= 1'b0;
         r_under    <= 1'b0;
         r_abort    <= 1'b0;
         r_sready   <= 1'b0;
      end else begin
         r_state    <= w_state_n;
         r_tx_shift <= w_tx_shift_n;
         r_rx_shift <= w_rx_shift_n;
         r_hold     <= w_hold_n;
         r_rx_data  <= w_rx_data_n;
         r_count    <= w_count_n;
         r_full     <= w_full_n;
         r_miso     <= w_miso_n;
         r_rx_valid <= w_rx_valid_n;
         r_under    <= w_under_n;
         r_abort    <= w_abort_n;
         r_sready   <= enable_i;
      end
   end

   always_comb begin
      w_state_n    = r_state;
      w_tx_shift_n = r_tx_shift;
      w_rx_shift_n = r_rx_shift;
      w_hold_n     = r_hold;
      w_rx_data_n  = r_rx_data;
      w_count_n    = r_count;
      w_full_n     = r_full;
      w_miso_n     = r_miso;
      w_rx_valid_n = 1'b0;
      w_under_n    = 1'b0;
      w_abort_n    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_ss_fall) w_state_n = ST_LOAD;
         end
         ST_LOAD: begin
            if (w_ss_lvl) begin
               w_state_n = ST_IDLE;
               w_abort_n = 1'b1;
            end else begin
               if (r_full) begin
                  w_tx_shift_n = r_hold;
                  w_full_n     = 1'b0;
               end else begin
                  w_tx_shift_n = '0;
                  w_under_n    = 1'b1;
               end
               w_miso_n  = w_tx_shift_n[WIDTH-1];
               w_count_n = '0;
               w_state_n = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (w_ss_lvl) begin
               w_state_n = ST_IDLE;
               w_abort_n = 1'b1;
            end else if (w_sample) begin
               w_rx_shift_n = {r_rx_shift[WIDTH-2:0], w_mosi};
               if (r_count == CT'(WIDTH-1)) begin
                  w_count_n = '0;
                  w_state_n = ST_DONE;
               end else begin
                  w_count_n = r_count + 1'b1;
               end
            end else if (w_drive && r_count != '0) begin
               // Bit 0 went out in LOAD; later bits advance on each fall.
               w_tx_shift_n = r_tx_shift << 1;
               w_miso_n     = r_tx_shift[WIDTH-2];
            end
         end
         ST_DONE: begin
            w_rx_data_n  = r_rx_shift;
            w_rx_valid_n = 1'b1;
            w_state_n    = w_ss_lvl ? ST_IDLE : ST_WAIT_FALL;
         end
         ST_WAIT_FALL: begin
            // ss_n high wins over a coincident final fall: frame over.
            if (w_ss_lvl) w_state_n = ST_IDLE;
            else if (w_drive) w_state_n = ST_LOAD;
         end
         default: w_state_n = ST_IDLE;
      endcase
      if (w_state_n == ST_IDLE) w_miso_n = 1'b0;
      // LOAD above saw the old full flag; a word captured now is for the next LOAD.
      if (tx_valid_i && !r_full) begin
         w_full_n = 1'b1;
         w_hold_n = tx_data_i;
      end
   end

   assign miso_o        = r_miso;
   assign slave_ready_o = r_sready;
   assign tx_ready_o    = ~r_full;
   assign rx_data_o     = r_rx_data;
   assign rx_valid_o    = r_rx_valid;
   assign tx_underrun_o = r_under;
   assign frame_abort_o = r_abort;

endmodule
